// File: rtl/gt_rx_frame_checker.sv
// Frame delimiter/checker for the word-aligned 32-bit GTX receive stream.
// Optional payload pattern check enabled by defining RX_FRAME_PAYLOAD_CHK_EN.
module gt_rx_frame_checker #(
  parameter int unsigned MAX_LEN    = 1024,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOCK_IDLES = 16
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic [31:0]      rx_data,
  input  logic [3:0]       rx_ctrl,
  output logic [31:0]      pl_data,
  output logic             pl_valid,
  output logic             pl_sop,
  output logic             pl_eop,
  output logic [7:0]       pl_type,
  output logic             frame_done,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             link_up
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned RUN_W = $clog2(LOCK_IDLES + 1);

  localparam logic [2:0] ERR_BAD_HDR  = 3'd1;
  localparam logic [2:0] ERR_TRUNC    = 3'd2;
  localparam logic [2:0] ERR_MISMATCH = 3'd3;
  localparam logic [2:0] ERR_NO_EOP   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_EOP} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic               mis_q, mis_d;
  logic [31:0]        pl_data_q, pl_data_d;
  logic               pl_valid_q, pl_valid_d;
  logic               pl_sop_q, pl_sop_d;
  logic               pl_eop_q, pl_eop_d;
  logic [7:0]         pl_type_q, pl_type_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [RUN_W-1:0]   idle_run_q, idle_run_d;
  logic               link_up_q, link_up_d;

  logic               is_idle, is_sop, is_eop, is_data, is_illegal;
  logic [LEN_W-1:0]   hdr_len;
  logic               hdr_ok;

  // Word classification
  always_comb begin
    is_idle    = (rx_ctrl == 4'b0001) && (rx_data[7:0] == 8'hBC);
    is_sop     = (rx_ctrl == 4'b0001) && (rx_data[7:0] == 8'hFB);
    is_eop     = (rx_ctrl == 4'b0001) && (rx_data[7:0] == 8'hFD);
    is_data    = (rx_ctrl == 4'b0000);
    is_illegal = !(is_idle || is_sop || is_eop || is_data);
    hdr_len    = rx_data[15:0];
    hdr_ok     = is_data && (hdr_len >= LEN_W'(1)) && (hdr_len <= LEN_W'(MAX_LEN));
  end

  // Frame FSM, payload forwarding and close reporting
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    k_d          = k_q;
    mis_d        = mis_q;
    pl_data_d    = pl_data_q;
    pl_valid_d   = 1'b0;
    pl_sop_d     = 1'b0;
    pl_eop_d     = 1'b0;
    pl_type_d    = pl_type_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (is_sop) state_d = S_HDR;
      end
      S_HDR: begin
        if (hdr_ok) begin
          state_d   = S_DATA;
          len_d     = hdr_len;
          k_d       = '0;
          mis_d     = 1'b0;
          pl_type_d = rx_data[23:16];
        end else begin
          frame_done_d = 1'b1;
          frame_err_d  = 1'b1;
          err_code_d   = ERR_BAD_HDR;
          state_d      = is_sop ? S_HDR : S_IDLE;
        end
      end
      S_DATA: begin
        if (is_data) begin
          pl_data_d  = rx_data;
          pl_valid_d = 1'b1;
          pl_sop_d   = (k_q == '0);
          pl_eop_d   = (k_q == len_q - LEN_W'(1));
`ifdef RX_FRAME_PAYLOAD_CHK_EN
          if (rx_data != {4{k_q[7:0]}}) mis_d = 1'b1;
`else
          mis_d = 1'b0;
`endif
          if (k_q == len_q - LEN_W'(1)) state_d = S_EOP;
          else k_d = k_q + LEN_W'(1);
        end else begin
          frame_done_d = 1'b1;
          frame_err_d  = 1'b1;
          err_code_d   = ERR_TRUNC;
          state_d      = is_sop ? S_HDR : S_IDLE;
        end
      end
      S_EOP: begin
        frame_done_d = 1'b1;
        if (is_eop) begin
          frame_err_d = mis_q;
          err_code_d  = mis_q ? ERR_MISMATCH : 3'd0;
          state_d     = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_NO_EOP;
          state_d     = is_sop ? S_HDR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating counters follow the registered close pulse by one cycle
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_done_q && !frame_err_q) begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end else if (frame_done_q) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Idle-run lock; once up, only an illegal word drops the link
  always_comb begin
    idle_run_d = idle_run_q;
    link_up_d  = link_up_q;
    if (is_illegal) begin
      idle_run_d = '0;
      link_up_d  = 1'b0;
    end else if (is_idle) begin
      if (idle_run_q != RUN_W'(LOCK_IDLES)) idle_run_d = idle_run_q + RUN_W'(1);
      if (idle_run_q >= RUN_W'(LOCK_IDLES - 1)) link_up_d = 1'b1;
    end else if (!link_up_q) begin
      idle_run_d = '0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      k_q          <= '0;
      mis_q        <= 1'b0;
      pl_data_q    <= '0;
      pl_valid_q   <= 1'b0;
      pl_sop_q     <= 1'b0;
      pl_eop_q     <= 1'b0;
      pl_type_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      idle_run_q   <= '0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      k_q          <= k_d;
      mis_q        <= mis_d;
      pl_data_q    <= pl_data_d;
      pl_valid_q   <= pl_valid_d;
      pl_sop_q     <= pl_sop_d;
      pl_eop_q     <= pl_eop_d;
      pl_type_q    <= pl_type_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      idle_run_q   <= idle_run_d;
      link_up_q    <= link_up_d;
    end
  end

  assign pl_data    = pl_data_q;
  assign pl_valid   = pl_valid_q;
  assign pl_sop     = pl_sop_q;
  assign pl_eop     = pl_eop_q;
  assign pl_type    = pl_type_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign link_up    = link_up_q;

endmodule

// File: tb/tb_gt_rx_frame_checker.sv
// Scoreboard bench for gt_rx_frame_checker: payload and frame-close expectations are
// queued as stimulus is driven and popped when the DUT reports them.
module tb_gt_rx_frame_checker;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned MAX_LEN = 1024;

  logic             rx_clk;
  logic             rst;
  logic [31:0]      rx_data;
  logic [3:0]       rx_ctrl;
  logic [31:0]      pl_data;
  logic             pl_valid;
  logic             pl_sop;
  logic             pl_eop;
  logic [7:0]       pl_type;
  logic             frame_done;
  logic             frame_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             link_up;

  gt_rx_frame_checker #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LOCK_IDLES(16)) dut (
    .rx_clk(rx_clk), .rst(rst), .rx_data(rx_data), .rx_ctrl(rx_ctrl),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_sop(pl_sop), .pl_eop(pl_eop),
    .pl_type(pl_type), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .link_up(link_up)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } pl_t;

  pl_t        pl_q[$];
  logic [3:0] done_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_pl  = 0;
  int exp_frm = 0;
  int exp_err = 0;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge rx_clk) begin
    if (pl_valid === 1'b1) begin
      pl_t e;
      n_pl++;
      n_cmp++;
      if (pl_q.size() == 0) begin
        n_mis++;
        $display("FAIL pl_unexpected: got data=%h sop=%b eop=%b, want no payload", pl_data, pl_sop, pl_eop);
      end else begin
        e = pl_q.pop_front();
        if ({pl_data, pl_sop, pl_eop} !== {e.d, e.s, e.e}) begin
          n_mis++;
          $display("FAIL pl_word: got data=%h sop=%b eop=%b, want data=%h sop=%b eop=%b",
                   pl_data, pl_sop, pl_eop, e.d, e.s, e.e);
        end
      end
    end
    if (frame_done === 1'b1) begin
      logic [3:0] c;
      n_cmp++;
      if (done_q.size() == 0) begin
        n_mis++;
        $display("FAIL close_unexpected: got err=%b code=%0d, want no close", frame_err, err_code);
      end else begin
        c = done_q.pop_front();
        if (c[3] ? ({frame_err, err_code} !== c) : (frame_err !== 1'b0)) begin
          n_mis++;
          $display("FAIL close: got err=%b code=%0d, want err=%b code=%0d", frame_err, err_code, c[3], c[2:0]);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] c);
    rx_data = d;
    rx_ctrl = c;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_word(32'h0000_00BC, 4'b0001);
  endtask

  task automatic send_sop();
    send_word(32'h0000_00FB, 4'b0001);
  endtask

  task automatic send_eop();
    send_word(32'h0000_00FD, 4'b0001);
  endtask

  task automatic send_hdr(input int len, input logic [7:0] typ);
    send_word({8'h00, typ, 16'(len)}, 4'b0000);
  endtask

  task automatic expect_close(input logic err, input logic [2:0] code);
    done_q.push_back({err, code});
    if (err) exp_err++;
    else exp_frm++;
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, b, b, b};
  endfunction

  // Sends payload words k0..k1-1 of a LEN-word frame; returns whether any differs from the pattern
  task automatic send_payload(input int len, input int k0, input int k1, input int bad_k,
                              input logic [31:0] bad_word, output logic mis);
    logic [31:0] w;
    mis = 1'b0;
    for (int k = k0; k < k1; k++) begin
      w = (k == bad_k) ? bad_word : pat(k);
`ifdef RX_FRAME_PAYLOAD_CHK_EN
      if (w !== pat(k)) mis = 1'b1;
`endif
      pl_q.push_back({w, (k == 0), (k == len - 1)});
      send_word(w, 4'b0000);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data = '0;
    rx_ctrl = '0;
    repeat (3) @(posedge rx_clk);
    #1;
    n_cmp++;
    if ({pl_valid, pl_sop, pl_eop, frame_done, frame_err, link_up} !== 6'b0 || pl_data !== 32'h0 ||
        pl_type !== 8'h0 || err_code !== 3'h0 || frame_cnt !== '0 || err_cnt !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got valid=%b done=%b link=%b fcnt=%0d ecnt=%0d, want all 0",
               pl_valid, frame_done, link_up, frame_cnt, err_cnt);
    end
    rst = 1'b0;
    send_idle(15);
    n_cmp++;
    if (link_up !== 1'b0) begin n_mis++; $display("FAIL link_15_idles: got %b want 0", link_up); end
    send_idle(1);
    n_cmp++;
    if (link_up !== 1'b1) begin n_mis++; $display("FAIL link_16_idles: got %b want 1", link_up); end
    send_idle(4);
    n_cmp++;
    if (frame_cnt !== '0 || err_cnt !== '0) begin
      n_mis++;
      $display("FAIL idle_counters: got fcnt=%0d ecnt=%0d want 0/0", frame_cnt, err_cnt);
    end
  endtask

  task automatic check_counts(input string name);
    send_idle(3);
    n_cmp++;
    if (frame_cnt !== CNT_W'(exp_frm) || err_cnt !== CNT_W'(exp_err)) begin
      n_mis++;
      $display("FAIL %s_counters: got fcnt=%0d ecnt=%0d want %0d/%0d", name, frame_cnt, err_cnt, exp_frm, exp_err);
    end
  endtask

  task automatic test_good_frame();
    logic mis;
    int   pl0;
    pl0 = n_pl;
    send_sop();
    send_hdr(256, 8'd8);
    send_payload(256, 0, 256, -1, 32'h0, mis);
    expect_close(mis, 3'd3);
    send_eop();
    check_counts("good");
    n_cmp++;
    if (pl_type !== 8'd8 || n_pl - pl0 != 256) begin
      n_mis++;
      $display("FAIL good_type_beats: got type=%0d beats=%0d want 8/256", pl_type, n_pl - pl0);
    end
  endtask

  task automatic test_mismatch();
    logic mis;
    send_sop();
    send_hdr(256, 8'd8);
    send_payload(256, 0, 256, 10, 32'hDEAD_BEEF, mis);
    expect_close(mis, 3'd3);
    send_eop();
    check_counts("mismatch");
  endtask

  task automatic test_trunc();
    logic mis;
    send_sop();
    send_hdr(256, 8'd8);
    send_payload(256, 0, 100, -1, 32'h0, mis);
    expect_close(1'b1, 3'd2);
    send_sop();
    send_hdr(4, 8'd3);
    send_payload(4, 0, 4, -1, 32'h0, mis);
    expect_close(mis, 3'd3);
    send_eop();
    check_counts("trunc");
    n_cmp++;
    if (pl_type !== 8'd3) begin n_mis++; $display("FAIL trunc_type: got %0d want 3", pl_type); end
  endtask

  task automatic test_bad_hdr();
    logic mis;
    send_sop();
    expect_close(1'b1, 3'd1);
    send_hdr(0, 8'd1);
    send_idle(2);
    send_sop();
    expect_close(1'b1, 3'd1);
    send_hdr(MAX_LEN + 1, 8'd1);
    send_idle(2);
    send_sop();
    expect_close(1'b1, 3'd1);
    send_sop();
    send_hdr(2, 8'd7);
    send_payload(2, 0, 2, -1, 32'h0, mis);
    expect_close(mis, 3'd3);
    send_eop();
    check_counts("bad_hdr");
    n_cmp++;
    if (pl_type !== 8'd7) begin n_mis++; $display("FAIL bad_hdr_type: got %0d want 7", pl_type); end
  endtask

  task automatic test_no_eop();
    logic mis;
    send_sop();
    send_hdr(4, 8'd2);
    send_payload(4, 0, 4, -1, 32'h0, mis);
    expect_close(1'b1, 3'd4);
    send_idle(1);
    send_sop();
    send_hdr(3, 8'd2);
    send_payload(3, 0, 3, -1, 32'h0, mis);
    expect_close(1'b1, 3'd4);
    send_sop();
    send_hdr(1, 8'd9);
    send_payload(1, 0, 1, -1, 32'h0, mis);
    expect_close(mis, 3'd3);
    send_eop();
    check_counts("no_eop");
    n_cmp++;
    if (pl_type !== 8'd9 || link_up !== 1'b1) begin
      n_mis++;
      $display("FAIL no_eop_type_link: got type=%0d link=%b want 9/1", pl_type, link_up);
    end
  endtask

  task automatic test_link_drop();
    send_word(32'h0000_0000, 4'b1111);
    n_cmp++;
    if (link_up !== 1'b0) begin n_mis++; $display("FAIL link_illegal: got %b want 0", link_up); end
    send_idle(16);
    n_cmp++;
    if (link_up !== 1'b1) begin n_mis++; $display("FAIL link_relock: got %b want 1", link_up); end
  endtask

  task automatic test_reset_mid();
    logic mis;
    send_sop();
    send_hdr(256, 8'd5);
    send_payload(256, 0, 50, -1, 32'h0, mis);
    rst = 1'b1;
    send_word(pat(50), 4'b0000);
    exp_frm = 0;
    exp_err = 0;
    n_cmp++;
    if ({pl_valid, pl_sop, pl_eop, frame_done, frame_err, link_up} !== 6'b0 || pl_data !== 32'h0 ||
        pl_type !== 8'h0 || frame_cnt !== '0 || err_cnt !== '0) begin
      n_mis++;
      $display("FAIL reset_mid: got valid=%b data=%h type=%0d fcnt=%0d ecnt=%0d link=%b, want all 0",
               pl_valid, pl_data, pl_type, frame_cnt, err_cnt, link_up);
    end
    rst = 1'b0;
    send_payload(256, 51, 53, -1, 32'h0, mis);
    pl_q.delete();
    send_idle(2);
    send_sop();
    send_hdr(8, 8'd6);
    send_payload(8, 0, 8, -1, 32'h0, mis);
    expect_close(mis, 3'd3);
    send_eop();
    check_counts("after_reset");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_mismatch();
    test_trunc();
    test_bad_hdr();
    test_no_eop();
    test_link_drop();
    test_reset_mid();
    send_idle(4);
    n_cmp++;
    if (pl_q.size() != 0 || done_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d payload / %0d closes pending, want 0/0", pl_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
